// File: rtl/sr_pulse_driver.sv
// Turns two bouncy pushbuttons into clean, mutually exclusive S/R pulses for a downstream SR latch.
// Latency: a stable press gives S/R DEBOUNCE_CYCLES+4 edges later; no backpressure, presses queue one deep.
module sr_pulse_driver #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_CYCLES    = 2,
  parameter int CNT_W           = 8
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic SET_BTN,
  input  logic RST_BTN,
  output logic S,
  output logic R,
  output logic BUSY,
  output logic CONFLICT
);

  localparam logic [CNT_W-1:0] DB_MAX     = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PULSE_S, PULSE_R, GUARD} state_t;

  // Channel index 0 is the set button, index 1 the reset button.
  logic [1:0]       btn;
  logic [1:0]       sync1, sync2, db, db_q, press;
  logic [CNT_W-1:0] db_cnt [2];

  state_t           state, state_nxt;
  logic [CNT_W-1:0] pulse_cnt, pulse_cnt_nxt;
  logic             s_pend, r_pend, s_pend_nxt, r_pend_nxt;
  logic             s_req, r_req;
  logic             s_nxt, r_nxt, busy_nxt, conflict_nxt;

  assign btn = {RST_BTN, SET_BTN};

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      sync1     <= '0;
      sync2     <= '0;
      db        <= '0;
      db_q      <= '0;
      press     <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      db_q  <= db;
      press <= db & ~db_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != db[i]) begin
          if (db_cnt[i] == DB_MAX) begin
            db[i]     <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= IDLE;
      pulse_cnt <= '0;
      s_pend    <= 1'b0;
      r_pend    <= 1'b0;
      S         <= 1'b0;
      R         <= 1'b0;
      BUSY      <= 1'b0;
      CONFLICT  <= 1'b0;
    end else begin
      state     <= state_nxt;
      pulse_cnt <= pulse_cnt_nxt;
      s_pend    <= s_pend_nxt;
      r_pend    <= r_pend_nxt;
      S         <= s_nxt;
      R         <= r_nxt;
      BUSY      <= busy_nxt;
      CONFLICT  <= conflict_nxt;
    end
  end

  assign s_req = s_pend | press[0];
  assign r_req = r_pend | press[1];

  // GUARD dispatches pending work exactly as IDLE would, so a queued press
  // starts right after the single low guard cycle.
  always_comb begin
    state_nxt     = state;
    pulse_cnt_nxt = pulse_cnt;
    s_pend_nxt    = s_req;
    r_pend_nxt    = r_req;
    case (state)
      IDLE, GUARD: begin
        pulse_cnt_nxt = '0;
        if (r_req) begin
          state_nxt  = PULSE_R;
          r_pend_nxt = 1'b0;
        end else if (s_req) begin
          state_nxt  = PULSE_S;
          s_pend_nxt = 1'b0;
        end else begin
          state_nxt  = IDLE;
        end
      end
      PULSE_S, PULSE_R: begin
        if (pulse_cnt == PULSE_LAST) begin
          state_nxt     = GUARD;
          pulse_cnt_nxt = '0;
        end else begin
          pulse_cnt_nxt = pulse_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt     = IDLE;
        pulse_cnt_nxt = '0;
      end
    endcase
  end

  always_comb begin
    s_nxt        = (state_nxt == PULSE_S);
    r_nxt        = (state_nxt == PULSE_R);
    busy_nxt     = (state_nxt != IDLE);
    conflict_nxt = press[0] & press[1];
  end

endmodule

// File: tb/tb_sr_pulse_driver.sv
// Directed bench for sr_pulse_driver: each step drives the buttons per clock edge
// and compares S/R/BUSY/CONFLICT with hand-computed edge windows.
module tb_sr_pulse_driver;

  logic CLK, RSTN, SET_BTN, RST_BTN;
  logic S, R, BUSY, CONFLICT;
  int   vectors;
  int   miscompares;

  sr_pulse_driver #(.DEBOUNCE_CYCLES(4), .PULSE_CYCLES(2), .CNT_W(8)) dut (
    .CLK(CLK), .RSTN(RSTN), .SET_BTN(SET_BTN), .RST_BTN(RST_BTN),
    .S(S), .R(R), .BUSY(BUSY), .CONFLICT(CONFLICT)
  );

  // Rising edges at t=10,20,...; falling edge at t=5 leaves room for reset release.
  initial begin
    CLK = 1'b1;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Edge k of the step is the k-th rising edge after the call; windows are [on, off).
  task automatic run(input string tag, input int n,
                     input int s_on, input int s_off, input int r_on, input int r_off,
                     input int es_on, input int es_off, input int er_on, input int er_off,
                     input int eb_on, input int eb_off, input int ec_at);
    for (int k = 0; k < n; k++) begin
      SET_BTN = (k >= s_on) && (k < s_off);
      RST_BTN = (k >= r_on) && (k < r_off);
      tick();
      chk($sformatf("%s S@%0d", tag, k), S, (k >= es_on) && (k < es_off));
      chk($sformatf("%s R@%0d", tag, k), R, (k >= er_on) && (k < er_off));
      chk($sformatf("%s BUSY@%0d", tag, k), BUSY, (k >= eb_on) && (k < eb_off));
      chk($sformatf("%s CONFLICT@%0d", tag, k), CONFLICT, k == ec_at);
      chk($sformatf("%s S&R@%0d", tag, k), S & R, 1'b0);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    RSTN    = 1'b0;
    SET_BTN = 1'b1;
    RST_BTN = 1'b1;

    #2;
    chk("rst S", S, 1'b0);
    chk("rst R", R, 1'b0);
    chk("rst BUSY", BUSY, 1'b0);
    chk("rst CONFLICT", CONFLICT, 1'b0);
    #3 RSTN = 1'b1;

    // Both held through reset: debounce together, R first then S after guard.
    run("reset_release", 35, 0, 20, 0, 20, 11, 13, 8, 10, 8, 14, 8);

    // Clean held press: one 2-cycle S pulse at edges 8-9, release ignored.
    run("clean", 35, 0, 20, 0, 0, 8, 10, 0, 0, 8, 11, -1);

    // Bounce every 2 cycles never reaches the debounce threshold.
    for (int k = 0; k < 22; k++) begin
      SET_BTN = (k < 12) && (((k / 2) % 2) == 0);
      RST_BTN = 1'b0;
      tick();
      chk($sformatf("bounce S@%0d", k), S, 1'b0);
      chk($sformatf("bounce BUSY@%0d", k), BUSY, 1'b0);
    end
    run("short3", 15, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, -1);
    run("press6", 25, 0, 6, 0, 0, 8, 10, 0, 0, 8, 11, -1);

    // Simultaneous presses.
    run("simul", 35, 0, 20, 0, 20, 11, 13, 8, 10, 8, 14, 8);

    // SET press lands while R is high: S starts one cycle after R falls.
    run("during", 35, 1, 20, 0, 20, 11, 13, 8, 10, 8, 14, -1);

    // Reset in the middle of an S pulse.
    SET_BTN = 1'b1;
    RST_BTN = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    chk("mid S before reset", S, 1'b1);
    chk("mid BUSY before reset", BUSY, 1'b1);
    #2 RSTN = 1'b0;
    #1;
    chk("mid S async", S, 1'b0);
    chk("mid R async", R, 1'b0);
    chk("mid BUSY async", BUSY, 1'b0);
    chk("mid CONFLICT async", CONFLICT, 1'b0);
    #2 RSTN = 1'b1;
    run("after_reset", 35, 0, 20, 0, 0, 8, 10, 0, 0, 8, 11, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
